m_issue_ctrl: RTL and testbench

- Sits between the decode/execute pipeline and the M-extension unit, upstream of it.
- Detects RV32M instructions and issues each one to the M unit with registered operands as a single-cycle valid pulse.
- Stalls the main pipeline on structural and RAW hazards against the in-flight M destination.
- Holds the M result in a writeback buffer until the shared register-file write port accepts it.

---
 rtl/m_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_m_issue_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_issue_ctrl.sv
// ---------------------------------------------------------------------------
// m_issue_ctrl
//
// Issue controller for the RV32M unit. It detects M-extension instructions in
// the decode stage and captures their operands. It issues each one to the M
// unit as a single-cycle m_valid pulse. It stalls decode on structural and RAW
// hazards against the in-flight destination. It holds the returned result in
// a writeback buffer until the shared register-file write port grants it.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   id_valid               decode-stage instruction valid
//   id_instruction         decode-stage instruction word
//   id_rs1_val/id_rs2_val  forwarded source operands
//   flush                  kills the decode-stage instruction only
//   stall                  hold the decode stage (combinational)
//   m_valid                one-cycle issue pulse to the M unit
//   m_instruction/m_rs1/m_rs2/m_rd  registered issue payload
//   m_busy                 M unit busy; m_valid is never raised while it is high
//   m_ready/m_wr/m_result/m_result_dest  M unit completion
//   wb_valid/wb_rd/wb_data writeback request held until wb_ack
//   wb_ack                 write-port grant
//   err                    sticky: watchdog timeout or destination-tag mismatch
// ---------------------------------------------------------------------------
module m_issue_ctrl #(
  parameter bit          ALLOW_OVERLAP  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [31:0] id_instruction,
  input  logic [31:0] id_rs1_val,
  input  logic [31:0] id_rs2_val,
  input  logic        flush,
  output logic        stall,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  output logic [4:0]  m_rd,
  input  logic        m_busy,
  input  logic        m_ready,
  input  logic        m_wr,
  input  logic [31:0] m_result,
  input  logic [4:0]  m_result_dest,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ack,
  output logic        err
);

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNCT7_M     = 7'b0000001;
  // Last WAIT cycle the watchdog tolerates: the counter is 0 in the first one.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic        id_is_m;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  pending_rd;
  logic        raw_hazard;
  logic        accept;
  logic        timeout_hit;
  logic        wb_take;

  assign id_is_m = (id_instruction[6:0] == OPCODE_OP) &&
                   (id_instruction[31:25] == FUNCT7_M);
  assign id_rs1  = id_instruction[19:15];
  assign id_rs2  = id_instruction[24:20];

  assign accept      = (state == S_IDLE) && id_valid && id_is_m && !flush;
  // m_ready in the final WAIT cycle takes priority over the watchdog.
  assign timeout_hit = (state == S_WAIT) && !m_ready && (wait_cnt == TIMEOUT_LAST);
  // x0 results are architecturally discarded, so they never reach writeback.
  assign wb_take     = m_wr && (m_rd != 5'd0);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_ISSUE;
      // Hold the issue slot until the unit is free so no pulse is lost.
      S_ISSUE: if (!m_busy) state_next = S_WAIT;
      S_WAIT: begin
        if (m_ready) begin
          state_next = wb_take ? S_WB : S_IDLE;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      S_WB:    if (wb_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    m_valid    = 1'b0;
    wb_valid   = 1'b0;
    pending_rd = m_rd;
    case (state)
      S_ISSUE: m_valid = !m_busy;
      S_WB: begin
        wb_valid   = 1'b1;
        pending_rd = wb_rd;
      end
      default: ;
    endcase
    // rs2 is compared for every opcode; a false stall on I-type is harmless.
    raw_hazard = (pending_rd != 5'd0) &&
                 ((id_rs1 == pending_rd) || (id_rs2 == pending_rd));
    stall = (state != S_IDLE) && id_valid && !flush &&
            (id_is_m || raw_hazard || !ALLOW_OVERLAP);
  end

  // Issue payload, watchdog counter, writeback buffer and sticky error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_instruction <= '0;
      m_rs1         <= '0;
      m_rs2         <= '0;
      m_rd          <= '0;
      wait_cnt      <= '0;
      wb_rd         <= '0;
      wb_data       <= '0;
      err           <= 1'b0;
    end else begin
      if (accept) begin
        m_instruction <= id_instruction;
        m_rs1         <= id_rs1_val;
        m_rs2         <= id_rs2_val;
        m_rd          <= id_instruction[11:7];
      end

      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if ((state == S_WAIT) && m_ready) begin
        if (m_result_dest != m_rd) err <= 1'b1;
        if (wb_take) begin
          wb_data <= m_result;
          wb_rd   <= m_rd;
        end
      end

      if (timeout_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m_issue_ctrl
//
// Directed plus randomized bench for m_issue_ctrl. The bench plays the M unit
// and the register-file write port. A transaction-level reference (busy flag,
// pending destination, expected writeback and error) predicts every output.
// Two instances share all inputs: one with ALLOW_OVERLAP=1, one with 0.
// ---------------------------------------------------------------------------
module tb_m_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instruction = '0;
  logic [31:0] id_rs1_val = '0;
  logic [31:0] id_rs2_val = '0;
  logic        flush = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_result_dest = '0;
  logic        wb_ack = 1'b0;

  logic        stall, m_valid, wb_valid, err;
  logic [31:0] m_instruction, m_rs1, m_rs2, wb_data;
  logic [4:0]  m_rd, wb_rd;

  logic        stall_b, m_valid_b, wb_valid_b, err_b;
  logic [31:0] m_instruction_b, m_rs1_b, m_rs2_b, wb_data_b;
  logic [4:0]  m_rd_b, wb_rd_b;

  m_issue_ctrl #(.ALLOW_OVERLAP(1'b1), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .flush(flush), .stall(stall),
    .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready), .m_wr(m_wr), .m_result(m_result),
    .m_result_dest(m_result_dest), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ack(wb_ack), .err(err)
  );

  m_issue_ctrl #(.ALLOW_OVERLAP(1'b0), .TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .flush(flush), .stall(stall_b),
    .m_valid(m_valid_b), .m_instruction(m_instruction_b), .m_rs1(m_rs1_b), .m_rs2(m_rs2_b),
    .m_rd(m_rd_b), .m_busy(m_busy), .m_ready(m_ready), .m_wr(m_wr), .m_result(m_result),
    .m_result_dest(m_result_dest), .wb_valid(wb_valid_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b),
    .wb_ack(wb_ack), .err(err_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state (transaction level).
  bit          busy = 1'b0;      // an M op is between accept and completion
  logic [4:0]  prd = '0;         // destination of that op
  logic [4:0]  last_rd = '0;     // last captured destination
  logic [4:0]  exp_wb_rd = '0;
  logic [31:0] exp_wb_data = '0;
  bit          exp_err = 1'b0;
  bit          rand_id = 1'b0;   // randomize decode traffic while an op is in flight

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mul_i(input logic [4:0] rd, rs1, rs2);
    return r_type(7'd1, 3'd0, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] div_i(input logic [4:0] rd, rs1, rs2);
    return r_type(7'd1, 3'd4, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
    return r_type(7'd0, 3'd0, rd, rs1, rs2);
  endfunction

  function automatic bit ref_is_m(input logic [31:0] instr);
    return (instr[6:0] == 7'h33) && (instr[31:25] == 7'h01);
  endfunction

  // Stall rule: only while an op is outstanding, never under flush.
  function automatic bit ref_stall(input bit bsy, input logic [4:0] pend,
                                   input logic [31:0] instr, input bit vld,
                                   input bit fl, input bit overlap);
    bit dep;
    dep = (pend != 5'd0) && ((instr[19:15] == pend) || (instr[24:20] == pend));
    return bsy && vld && !fl && (ref_is_m(instr) || dep || !overlap);
  endfunction

  // RV32M arithmetic the bench's M unit returns.
  function automatic logic [31:0] ref_alu(input logic [31:0] instr, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    case (instr[14:12])
      3'd1:    return sp[63:32];
      3'd3:    return up[63:32];
      3'd5:    return (b == 0) ? 32'hffff_ffff : a / b;
      3'd7:    return (b == 0) ? a : a % b;
      default: return a * b;
    endcase
  endfunction

  task automatic check_stall(input string tag);
    check({tag, "_stall"}, stall, ref_stall(busy, prd, id_instruction, id_valid, flush, 1'b1));
    check({tag, "_stall_nooverlap"}, stall_b,
          ref_stall(busy, prd, id_instruction, id_valid, flush, 1'b0));
  endtask

  task automatic drive_rand_id();
    logic [4:0] r1, r2;
    r1 = ($urandom_range(0, 2) == 0) ? prd : 5'($urandom_range(0, 31));
    r2 = ($urandom_range(0, 2) == 0) ? prd : 5'($urandom_range(0, 31));
    id_valid       = 1'($urandom_range(0, 1));
    id_instruction = ($urandom_range(0, 1) == 0) ? add_i(5'd9, r1, r2) : mul_i(5'd9, r1, r2);
    flush          = ($urandom_range(0, 5) == 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; id_valid = 1'b0; flush = 1'b0; m_ready = 1'b0; m_wr = 1'b0;
    wb_ack = 1'b0;
    tick();
    tick();
    busy = 1'b0; prd = '0; last_rd = '0; exp_err = 1'b0;
    resetn = 1'b1;
  endtask

  // Present an M op in IDLE; it is accepted at the next edge and pulses m_valid.
  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_instruction = instr; id_rs1_val = a; id_rs2_val = b; flush = 1'b0;
    #1 check_stall("issue_idle");
    tick();
    id_valid = 1'b0;
    #1;
    check("issue_m_valid", m_valid, 1);
    check("issue_m_instruction", m_instruction, instr);
    check("issue_m_rs1", m_rs1, a);
    check("issue_m_rs2", m_rs2, b);
    check("issue_m_rd", m_rd, instr[11:7]);
    busy = 1'b1; prd = instr[11:7]; last_rd = instr[11:7];
  endtask

  // Called in the m_valid cycle; m_ready arrives lat cycles later.
  task automatic respond(input int lat, input bit wr, input logic [4:0] dest,
                         input logic [31:0] res);
    repeat (lat) begin
      tick();
      if (rand_id) drive_rand_id();
      #1;
      check("wait_m_valid_low", m_valid, 0);
      check_stall("wait");
    end
    if (rand_id) begin id_valid = 1'b0; flush = 1'b0; end
    m_ready = 1'b1; m_wr = wr; m_result = res; m_result_dest = dest;
    tick();
    m_ready = 1'b0; m_wr = 1'b0;
    #1;
    if (dest != prd) exp_err = 1'b1;
    check("ready_err", err, exp_err);
    if (wr && prd != 5'd0) begin
      exp_wb_rd = prd; exp_wb_data = res;
      check("wb_valid_set", wb_valid, 1);
      check("wb_rd", wb_rd, exp_wb_rd);
      check("wb_data", wb_data, exp_wb_data);
    end else begin
      busy = 1'b0;
      check("no_wb_valid", wb_valid, 0);
    end
  endtask

  // Called in the first WB cycle; the grant comes after hold further cycles.
  task automatic ack_wb(input int hold);
    repeat (hold) begin
      tick();
      if (rand_id) drive_rand_id();
      #1;
      check("wb_hold_valid", wb_valid, 1);
      check("wb_hold_rd", wb_rd, exp_wb_rd);
      check("wb_hold_data", wb_data, exp_wb_data);
      check_stall("wb");
    end
    if (rand_id) begin id_valid = 1'b0; flush = 1'b0; end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    busy = 1'b0;
    #1;
    check("wb_valid_drop", wb_valid, 0);
    check_stall("after_ack");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish observed=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [31:0] a, b, instr, res;
    logic [4:0]  rd;
    logic [2:0]  f3;

    // Reset state.
    tick();
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_err", err, 0);
    check("rst_m_rd", m_rd, 0);
    check("rst_m_rs1", m_rs1, 0);
    check("rst_m_instruction", m_instruction, 0);
    check("rst_wb_data", wb_data, 0);
    do_reset();

    // MUL x5,x1,x2 = 7*6, ready 3 cycles after m_valid.
    instr = mul_i(5'd5, 5'd1, 5'd2);
    issue(instr, 32'd7, 32'd6);
    respond(3, 1'b1, 5'd5, ref_alu(instr, 32'd7, 32'd6));
    check("mul_result_42", wb_data, 32'd42);
    ack_wb(2);

    // Back-to-back MUL x5 then DIV x6: DIV stalls until the ack.
    a = $urandom; b = $urandom;
    instr = mul_i(5'd5, 5'd1, 5'd2);
    issue(instr, a, b);
    id_valid = 1'b1; id_instruction = div_i(5'd6, 5'd3, 5'd4);
    id_rs1_val = $urandom; id_rs2_val = $urandom;
    #1 check_stall("b2b_issue");
    respond(2, 1'b1, 5'd5, ref_alu(instr, a, b));
    ack_wb(1);
    check("b2b_no_early_issue", m_valid, 0);
    a = $urandom; b = $urandom_range(1, 1000);
    instr = div_i(5'd6, 5'd3, 5'd4);
    issue(instr, a, b);
    respond(4, 1'b1, 5'd6, ref_alu(instr, a, b));
    ack_wb(0);

    // RAW on rs1 and rs2, independent ADD, and non-M in IDLE is not issued.
    instr = mul_i(5'd5, 5'd1, 5'd2);
    issue(instr, 32'd3, 32'd4);
    id_valid = 1'b1; id_instruction = add_i(5'd7, 5'd5, 5'd1);
    #1 check_stall("raw_rs1");
    id_instruction = add_i(5'd7, 5'd1, 5'd5);
    #1 check_stall("raw_rs2");
    id_instruction = add_i(5'd7, 5'd3, 5'd4);
    #1 check_stall("independent");
    id_instruction = add_i(5'd7, 5'd5, 5'd1);
    respond(3, 1'b1, 5'd5, 32'd12);
    ack_wb(1);
    tick();
    check("add_not_issued", m_valid, 0);
    id_valid = 1'b0;

    // Pending x0 creates no RAW hazard and never writes back.
    instr = mul_i(5'd0, 5'd1, 5'd2);
    issue(instr, 32'd9, 32'd9);
    id_valid = 1'b1; id_instruction = add_i(5'd7, 5'd0, 5'd0);
    #1 check_stall("x0_no_raw");
    id_valid = 1'b0;
    respond(2, 1'b1, 5'd0, 32'd81);
    id_valid = 1'b1; id_instruction = mul_i(5'd8, 5'd1, 5'd2);
    #1 check_stall("x0_back_idle");
    id_valid = 1'b0;

    // Flush in IDLE: no capture, no pulse.
    id_valid = 1'b1; flush = 1'b1; id_instruction = mul_i(5'd12, 5'd1, 5'd2);
    #1 check_stall("flush_idle");
    tick();
    id_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_no_m_valid", m_valid, 0);
    check("flush_m_rd_kept", m_rd, last_rd);
    tick();
    check("flush_no_m_valid_late", m_valid, 0);

    // Flush during WAIT: stall forced low, older op still writes back.
    a = $urandom; b = $urandom;
    instr = mul_i(5'd9, 5'd1, 5'd2);
    issue(instr, a, b);
    id_valid = 1'b1; flush = 1'b1; id_instruction = mul_i(5'd10, 5'd9, 5'd9);
    tick();
    check_stall("flush_wait");
    check("flush_wait_m_valid", m_valid, 0);
    id_valid = 1'b0; flush = 1'b0;
    respond(2, 1'b1, 5'd9, ref_alu(instr, a, b));
    ack_wb(1);

    // Destination-tag mismatch sets err; write still goes to m_rd.
    instr = mul_i(5'd5, 5'd1, 5'd2);
    issue(instr, 32'd2, 32'd3);
    respond(2, 1'b1, 5'd3, 32'd6);
    check("mismatch_err", err, 1);
    ack_wb(0);

    // Watchdog: 64 WAIT cycles without m_ready abort the op.
    do_reset();
    issue(mul_i(5'd5, 5'd1, 5'd2), 32'd1, 32'd1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      check("timeout_err_low", err, 0);
      check("timeout_no_wb", wb_valid, 0);
    end
    tick();
    busy = 1'b0;
    exp_err = 1'b1;
    check("timeout_err", err, 1);
    check("timeout_no_wb_after", wb_valid, 0);
    instr = mul_i(5'd11, 5'd1, 5'd2);
    issue(instr, 32'd5, 32'd5);
    respond(1, 1'b1, 5'd11, 32'd25);
    check("err_sticky", err, 1);
    ack_wb(0);

    // m_ready in the last tolerated WAIT cycle wins over the watchdog.
    do_reset();
    instr = mul_i(5'd5, 5'd1, 5'd2);
    issue(instr, 32'd4, 32'd4);
    respond(64, 1'b1, 5'd5, 32'd16);
    check("ready_wins_no_err", err, 0);
    ack_wb(0);

    // Reset during WB aborts the writeback.
    issue(mul_i(5'd5, 5'd1, 5'd2), 32'd2, 32'd2);
    respond(1, 1'b1, 5'd5, 32'd4);
    resetn = 1'b0;
    tick();
    check("rst_in_wb_wb_valid", wb_valid, 0);
    check("rst_in_wb_m_valid", m_valid, 0);
    check("rst_in_wb_wb_rd", wb_rd, 0);
    check("rst_in_wb_m_rd", m_rd, 0);
    do_reset();

    // Randomized ops with random decode traffic while each is outstanding.
    rand_id = 1'b1;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd3;
        3: f3 = 3'd5;
        default: f3 = 3'd7;
      endcase
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      instr = r_type(7'd1, f3, rd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      a = $urandom; b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      res = ref_alu(instr, a, b);
      issue(instr, a, b);
      respond($urandom_range(1, 6), ($urandom_range(0, 3) != 0), rd, res);
      if (busy) ack_wb($urandom_range(0, 3));
      check("rand_err_clear", err, 0);
    end
    rand_id = 1'b0;
    id_valid = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
